// File: rtl/dac_sample_tx.sv
// dac_sample_tx
// Transmit end of the 8-bit parallel converter path. Samples arrive from
// fabric over a valid/ready handshake into a small FIFO. An update engine
// pops one sample per period of P = max(div,1)+1 clocks. It drives the
// sample onto the DAC data pins together with a forwarded latch clock,
// whose rising edge sits in the middle of the data eye.
//
// Handshake: a transfer happens on a rising clk_pin_p edge where s_valid
// and s_ready are both high. s_ready depends only on the registered FIFO
// level, never on s_valid. The source must hold s_data stable while
// s_valid is high and s_ready is low.
//
// Optional feature: define DAC_TX_OFFSET_BIN_EN to treat samples as two's
// complement and emit offset binary (MSB inverted, idle code 8'h80).
// Otherwise samples pass straight through and the idle code is 8'h00.
//
// Ports
//   clk_pin_p     system clock, rising edge
//   rst_pin       asynchronous active-low reset
//   s_data        sample input
//   s_valid       s_data is valid
//   s_ready       FIFO not full
//   enable        run the update engine
//   div           update period select, P = max(div,1)+1
//   underrun_clr  pulse that clears underrun
//   dac_data      registered DAC data pins
//   dac_clk       registered forwarded DAC latch clock
//   underrun      sticky: an update tick found the FIFO empty
//   fifo_level    FIFO occupancy
//   fsm_state     debug view of the engine state (0 = IDLE, 1 = RUN)
module dac_sample_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 8,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic              clk_pin_p,
  input  logic              rst_pin,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div,
  input  logic              underrun_clr,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_clk,
  output logic              underrun,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              fsm_state
);

`ifdef DAC_TX_OFFSET_BIN_EN
  localparam logic [DATA_W-1:0] ZERO_CODE = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] ZERO_CODE = '0;
`endif

  localparam logic [DIV_W-1:0] ONE_DIV = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    cnt, cnt_nxt;
  logic [DIV_W-1:0]    div_q, div_q_nxt;
  logic [DIV_W-1:0]    p_last, p_last_nxt;
  logic [DIV_W:0]      half_nxt;
  logic                tick, dac_clk_nxt;
  logic                push, pop, fifo_empty;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];

  function automatic logic [DATA_W-1:0] to_code(input logic [DATA_W-1:0] x);
`ifdef DAC_TX_OFFSET_BIN_EN
    return {~x[DATA_W-1], x[DATA_W-2:0]};
`else
    return x;
`endif
  endfunction

  assign fsm_state  = (state == RUN);
  assign fifo_empty = (fifo_level == '0);
  assign s_ready    = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign pop        = tick && !fifo_empty;

  // P-1 for the period currently running.
  assign p_last = (div_q == '0) ? ONE_DIV : div_q;

  // State register
  always_ff @(posedge clk_pin_p or negedge rst_pin) begin
    if (!rst_pin) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / period logic. Dropping enable abandons the period at once,
  // so a tick needs enable high in its cycle as well.
  always_comb begin
    cnt_nxt   = '0;
    div_q_nxt = div_q;
    tick      = 1'b0;
    if (state == RUN && enable) begin
      if (cnt == p_last) begin
        tick      = 1'b1;
        div_q_nxt = div;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (state == IDLE && enable) begin
      div_q_nxt = div;
    end
    // The latch clock is registered, so it is derived from the values
    // cnt and div_q take on the coming edge. That keeps it aligned with cnt.
    p_last_nxt  = (div_q_nxt == '0) ? ONE_DIV : div_q_nxt;
    half_nxt    = ({1'b0, p_last_nxt} + 1'b1) >> 1;
    dac_clk_nxt = (state_nxt == RUN) && ({1'b0, cnt_nxt} >= half_nxt);
  end

  // Datapath registers
  always_ff @(posedge clk_pin_p or negedge rst_pin) begin
    if (!rst_pin) begin
      cnt        <= '0;
      div_q      <= '0;
      dac_clk    <= 1'b0;
      dac_data   <= ZERO_CODE;
      underrun   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      cnt     <= cnt_nxt;
      div_q   <= div_q_nxt;
      dac_clk <= dac_clk_nxt;
      if (pop) begin
        dac_data <= to_code(mem[rd_ptr]);
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      // A set in the same cycle as a clear takes priority.
      if (tick && fifo_empty) underrun <= 1'b1;
      else if (underrun_clr)  underrun <= 1'b0;
    end
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clk_pin_p) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: tb/tb_dac_sample_tx.sv
// Directed bench for dac_sample_tx: reset values, FIFO fill and backpressure,
// the update cadence at P=4 and P=2, enable drop mid-period, asynchronous
// reset mid-period, underrun set/clear priority and the output code mapping.
module tb_dac_sample_tx;

`ifdef DAC_TX_OFFSET_BIN_EN
  localparam logic [7:0] ZERO   = 8'h80;
  localparam logic [7:0] EXP_LO = 8'h80;
  localparam logic [7:0] EXP_HI = 8'h7F;
`else
  localparam logic [7:0] ZERO   = 8'h00;
  localparam logic [7:0] EXP_LO = 8'h00;
  localparam logic [7:0] EXP_HI = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       enable;
  logic [7:0] div;
  logic       underrun_clr;
  logic [7:0] dac_data;
  logic       dac_clk;
  logic       underrun;
  logic [3:0] fifo_level;
  logic       fsm_state;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;
  logic xfer;

  dac_sample_tx dut (
    .clk_pin_p    (clk),
    .rst_pin      (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .enable       (enable),
    .div          (div),
    .underrun_clr (underrun_clr),
    .dac_data     (dac_data),
    .dac_clk      (dac_clk),
    .underrun     (underrun),
    .fifo_level   (fifo_level),
    .fsm_state    (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Expected output code for a given input sample.
  function automatic logic [7:0] code(input logic [7:0] x);
`ifdef DAC_TX_OFFSET_BIN_EN
    return {~x[7], x[6:0]};
`else
    return x;
`endif
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; enable = 1'b0;
    div = '0; underrun_clr = 1'b0;
    #2;
    check("rst_data", 32'(dac_data), 32'(ZERO));
    check("rst_clk", 32'(dac_clk), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ready", 32'(s_ready), 1);
    check("rst_state", 32'(fsm_state), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Push three samples while idle
    s_valid = 1'b1;
    s_data = 8'h11; step();
    s_data = 8'h22; step();
    s_data = 8'h33; step();
    s_valid = 1'b0;
    check("idle_level", 32'(fifo_level), 3);
    check("idle_data", 32'(dac_data), 32'(ZERO));
    check("idle_clk", 32'(dac_clk), 0);
    check("idle_underrun", 32'(underrun), 0);

    // P = 4 cadence: step k lands on cnt = k % 4
    div = 8'd3; enable = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      step();
      check("p4_clk", 32'(dac_clk), ((k % 4) >= 2) ? 1 : 0);
      check("p4_data", 32'(dac_data),
            32'((k < 4) ? ZERO : (k < 8) ? code(8'h11) : (k < 12) ? code(8'h22) : code(8'h33)));
      check("p4_underrun", 32'(underrun), (k == 16) ? 1 : 0);
      if (k == 0) check("p4_state", 32'(fsm_state), 1);
    end
    check("p4_level", 32'(fifo_level), 0);
    enable = 1'b0; step();
    check("p4_off_state", 32'(fsm_state), 0);
    check("p4_off_clk", 32'(dac_clk), 0);
    check("p4_off_data", 32'(dac_data), 32'(code(8'h33)));
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    check("clr_underrun", 32'(underrun), 0);

    // Fill: nine back-to-back pushes, the ninth is refused
    s_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s_data = 8'h40 + 8'(i);
      step();
      if (i == 6) check("fill_ready7", 32'(s_ready), 1);
      if (i == 7) check("fill_ready8", 32'(s_ready), 0);
      if (i == 7) check("fill_level8", 32'(fifo_level), 8);
    end
    check("fill_level9", 32'(fifo_level), 8);
    check("fill_ready9", 32'(s_ready), 0);

    // P = 2 with a continuous stream starting at 8'h48
    s_data = 8'h48; div = 8'd0; enable = 1'b1;
    step();
    check("p2_state", 32'(fsm_state), 1);
    check("p2_clk0", 32'(dac_clk), 0);
    for (int k = 1; k <= 22; k++) begin
      xfer = s_valid && s_ready;
      step();
      if (xfer) s_data = s_data + 8'd1;
      check("p2_clk", 32'(dac_clk), k % 2);
      check("p2_data", 32'(dac_data),
            32'((k < 2) ? code(8'h33) : code(8'h40 + 8'(k / 2 - 1))));
    end
    s_valid = 1'b0; enable = 1'b0;
    check("p2_underrun", 32'(underrun), 0);
    check("p2_level", 32'(fifo_level), 7);
    step();
    check("p2_off_state", 32'(fsm_state), 0);

    // Enable dropped at cnt = 1 with P = 4
    div = 8'd3; enable = 1'b1;
    step(); step();
    enable = 1'b0; step();
    check("drop_state", 32'(fsm_state), 0);
    check("drop_clk", 32'(dac_clk), 0);
    check("drop_level", 32'(fifo_level), 7);
    check("drop_data", 32'(dac_data), 32'(code(8'h4A)));
    enable = 1'b1; step();
    check("re_state", 32'(fsm_state), 1);
    check("re_clk0", 32'(dac_clk), 0);
    step();
    check("re_clk1", 32'(dac_clk), 0);
    step();
    check("re_clk2", 32'(dac_clk), 1);
    step();
    check("re_clk3", 32'(dac_clk), 1);
    check("re_data3", 32'(dac_data), 32'(code(8'h4A)));
    step();
    check("re_data", 32'(dac_data), 32'(code(8'h4B)));
    check("re_level", 32'(fifo_level), 6);
    check("re_clk_wrap", 32'(dac_clk), 0);

    // Asynchronous reset while dac_clk is high
    step(); step();
    check("mid_clk_hi", 32'(dac_clk), 1);
    rst_n = 1'b0; #1;
    check("arst_clk", 32'(dac_clk), 0);
    check("arst_data", 32'(dac_data), 32'(ZERO));
    check("arst_level", 32'(fifo_level), 0);
    check("arst_ready", 32'(s_ready), 1);
    check("arst_state", 32'(fsm_state), 0);
    enable = 1'b0; step();
    rst_n = 1'b1; step();

    // Clear coinciding with an empty tick: set wins
    div = 8'd3; enable = 1'b1;
    step(); step(); step(); step();
    check("uc_pre", 32'(underrun), 0);
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    check("uc_setwins", 32'(underrun), 1);
    check("uc_data", 32'(dac_data), 32'(ZERO));
    underrun_clr = 1'b1; step(); underrun_clr = 1'b0;
    check("uc_clear", 32'(underrun), 0);
    enable = 1'b0; step();

    // Code mapping of the extreme samples
    rst_n = 1'b0; #1;
    check("map_rst", 32'(dac_data), 32'(ZERO));
    step(); rst_n = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h00; step();
    s_data = 8'hFF; step();
    s_valid = 1'b0;
    div = 8'd1; enable = 1'b1;
    step(); step(); step();
    check("map_lo", 32'(dac_data), 32'(EXP_LO));
    step(); step();
    check("map_hi", 32'(dac_data), 32'(EXP_HI));
    enable = 1'b0; step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dac_sample_tx.md
# dac_sample_tx

Transmit end of the board's 8-bit parallel converter path, the counterpart to the registered ADC_in capture. Accepts samples from fabric over a valid/ready handshake into a small FIFO. Drives them onto the DAC data pins at a programmable update rate, together with a forwarded DAC latch clock centred in the data eye. Sits in the clk_pin_p domain beside the ADC capture logic and the count_test counters.

## Interface
- DATA_W, 8: sample and DAC bus width.
- FIFO_DEPTH, 8: sample FIFO entries; power of two, at least 2.
- DIV_W, 8: width of the update-period divider input.

- clk_pin_p  in  1: system clock; all logic rises on this edge.
- rst_pin  in  1: asynchronous active-low reset. Assertion is immediate; release is synchronous to clk_pin_p and is done upstream.
- s_data  in  DATA_W: sample to transmit.
- s_valid  in  1: s_data is valid.
- s_ready  out  1: FIFO not full; a transfer occurs when s_valid and s_ready are both high at a rising edge.
- enable  in  1: run the DAC update engine.
- div  in  DIV_W: update period is P = max(div,1)+1 clocks.
- underrun_clr  in  1: single-cycle pulse that clears underrun.
- dac_data  out  DATA_W: registered DAC data pins.
- dac_clk  out  1: registered forwarded DAC latch clock; the DAC latches on its rising edge.
- underrun  out  1: sticky flag, set when an update tick finds the FIFO empty.
- fifo_level  out  log2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- FIFO: synchronous, registered outputs, no write-to-read bypass.
  - s_ready = (fifo_level != FIFO_DEPTH).
  - A push and a pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE and RUN.
  - IDLE to RUN when enable = 1.
  - RUN to IDLE when enable = 0, immediately, abandoning the current period.
- Period counter cnt runs 0..P-1 in RUN and is held at 0 in IDLE.
- div is sampled into div_q on entry to RUN and at every cnt = P-1. Changing div mid-period takes effect at the next period.
- Tick: occurs when cnt = P-1 in RUN.
  - FIFO non-empty: pop the head; dac_data takes the head value on the same edge cnt returns to 0.
  - FIFO empty: dac_data holds its value, underrun is set, nothing is popped.
- dac_clk = 1 when in RUN and cnt is at least floor(P/2), otherwise 0. It is a registered output, aligned with cnt.
- IDLE:
  - dac_clk = 0 and dac_data holds its last value.
  - The FIFO keeps accepting samples, and underrun is not set.
- underrun:
  - Set by an empty tick.
  - Cleared by underrun_clr.
  - If set and clear coincide, set wins.
- Reset values:
  - dac_data = ZERO_CODE (see Configuration).
  - dac_clk = 0, underrun = 0, fifo_level = 0, s_ready = 1.
  - FSM = IDLE, cnt = 0.
  - FIFO contents are don't-care.

## Timing
- First period after enable rises:
  - Cycle 0 (first RUN cycle): cnt = 0.
  - First tick at cnt = P-1.
  - New dac_data is visible at cnt = 0 of the next period.
- dac_clk rising edge at cnt = floor(P/2) gives floor(P/2) clocks of setup and P-floor(P/2) clocks of hold around the DAC latch edge.
- Minimum P = 2 (div = 0 or 1): dac_clk toggles every cycle and dac_data updates every 2 cycles.
- A sample pushed at edge t is eligible for a tick at t+1 or later. A push in the tick cycle into an empty FIFO still underruns.
- s_ready deasserts in the cycle after the push that fills the FIFO. With FIFO_DEPTH = 8 and no pops, the 8th push drives s_ready = 0.
- rst_pin assertion in mid-period forces all outputs to their reset values asynchronously.

## Configuration
- DAC_TX_OFFSET_BIN_EN defined:
  - Input samples are two's complement.
  - dac_data = sample with its MSB inverted (offset binary).
  - ZERO_CODE = 8'h80.
- Not defined:
  - Samples pass straight through.
  - ZERO_CODE = 8'h00.

## Test plan
- Reset, then push 8'h11, 8'h22, 8'h33 with enable = 0 → fifo_level = 3, dac_data = ZERO_CODE, dac_clk = 0, underrun = 0.
- div = 3, enable = 1 → updates at cnt = 0 of each period, every 4 clocks; dac_data = 11, 22, 33; dac_clk high on cnt 2..3; fourth tick sets underrun and dac_data holds 33.
- Push 9 samples back-to-back with enable = 0 → s_ready = 0 after the 8th push, the 9th sample is not accepted, fifo_level = 8.
- div = 0 with a continuous sample stream → P = 2; dac_clk toggles every cycle; one sample consumed per 2 cycles; no underrun.
- enable dropped at cnt = 1 with P = 4 → FSM = IDLE next cycle, dac_clk = 0, no pop; re-enable restarts at cnt = 0. Separately, underrun_clr in the same cycle as an empty tick → underrun stays 1.
- Build with DAC_TX_OFFSET_BIN_EN, push 8'h00 and 8'hFF → reset dac_data = 8'h80; outputs 8'h80 then 8'h7F.
